sccb_write_scheduler: RTL and testbench
=======================================

Name: sccb_write_scheduler

Overview:
Sequences OV7670 register configuration over a shared SCCB write engine and arbitrates engine access between the built-in init table walker and a runtime host write port. It walks an external register table, issues one 3-phase SCCB write per entry through a req/done handshake, and inserts post-write delays (a long delay after soft reset). It retries NACKed writes and reports init completion or failure. It sits between the camera-control logic and the byte-level SCCB engine.

Parameters:
NUM_ENTRIES, 17, number of table entries walked (indices 0..NUM_ENTRIES-1)
IDX_W, 5, width of table index
DELAY_SOFTRST, 100000, cycles waited at power-up/start and after any soft-reset write
DELAY_WRITE, 5000, cycles waited after every other write and before each retry
DELAY_UNIT, 1000, cycles per count of a delay-marker entry
CNT_W, 20, delay counter width (must hold 255*DELAY_UNIT and DELAY_SOFTRST)
MAX_RETRY, 3, retries per table entry after first NACK

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: (re)run init sequence
tbl_idx  out  IDX_W  table lookup index
tbl_data  in  16  {reg_addr, reg_data}, combinational from tbl_idx, valid same cycle
host_req  in  1  host write request, held until host_ack
host_addr  in  8  host register address, stable while host_req
host_data  in  8  host register data, stable while host_req
host_ack  out  1  one-cycle pulse: host write finished
host_err  out  1  valid with host_ack: 1 = engine NACK
eng_req  out  1  write request to SCCB engine, held until eng_done
eng_reg_addr  out  8  register address to engine, stable while eng_req
eng_reg_data  out  8  register data to engine, stable while eng_req
eng_done  in  1  one-cycle pulse from engine: write (incl. STOP) complete
eng_nack  in  1  valid with eng_done: 1 = any byte NACKed
busy  out  1  high whenever not in IDLE
init_done  out  1  sticky: last init sequence completed
init_err  out  1  sticky: last init sequence aborted

Behaviour:
- Reset: all outputs 0, tbl_idx=0, state IDLE, counters 0, retry count 0, pending-start flag 0. Auto-start is not implied; start is required.
- States: IDLE, WAIT, FETCH, ISSUE, HOST, DONE.
- IDLE: start (or pending-start flag) has priority over host_req. On start: init_done=0, init_err=0, tbl_idx=0, retry=0, counter=DELAY_SOFTRST-1, go to WAIT next cycle. Else if host_req: latch host_addr/data into eng_reg_*, eng_req=1, go to HOST.
- WAIT: counter decrements each cycle; exits when counter==0, so WAIT lasts exactly N cycles for a load of N-1. Next state is FETCH. A delay load of 0 total cycles is never produced.
- FETCH (1 cycle): sample tbl_data.
  - addr 8'hFF: end marker. Go to DONE.
  - addr 8'hFE: delay marker. If data==0, advance the index and stay in FETCH. Otherwise counter=data*DELAY_UNIT-1, advance the index, go to WAIT.
  - Else: register tbl_data into eng_reg_addr/eng_reg_data, eng_req=1, go to ISSUE.
- ISSUE: hold eng_req and eng_reg_* until eng_done. On the eng_done cycle, eng_req drops on the next edge.
  - ACK, tbl_idx==NUM_ENTRIES-1: go to DONE.
  - ACK, other index: tbl_idx+1, retry=0. counter=DELAY_SOFTRST-1 if eng_reg_addr==8'h12 and eng_reg_data[7]==1, else DELAY_WRITE-1. Go to WAIT.
  - NACK, retry<MAX_RETRY: retry+1, tbl_idx unchanged, counter=DELAY_WRITE-1, go to WAIT.
  - NACK, retry==MAX_RETRY: init_err=1, go to IDLE. init_done stays 0.
- Index advance past NUM_ENTRIES-1 through a marker entry is treated as reaching the end: go to DONE.
- DONE (1 cycle): init_done=1, go to IDLE.
- HOST: hold eng_req until eng_done. In that cycle, pulse host_ack with host_err=eng_nack, drop eng_req, return to IDLE. Host writes are never retried.
- start while not IDLE: set the pending-start flag.
  - During an init run (WAIT/FETCH/ISSUE): the in-flight engine write completes, then the sequence restarts from index 0 with the full DELAY_SOFTRST.
  - During HOST: the host write completes and is acked, then the init run begins.
  - The flag clears when the run starts.
- host_req during an init run: no ack and no engine access until IDLE is reached.
- eng_done outside ISSUE/HOST: ignored.
- busy=1 in every state except IDLE.
- rst mid-write: eng_req drops immediately (async). The engine is required to abort on its own reset.

Test Plan:
- Reset, start pulse, 17-entry table with entry0=16'h1280, engine acks after 40 cycles → 100000-cycle wait, then 17 writes in order. 100000-cycle gap after entry0, 5000-cycle gaps after the others. init_done=1 after the last eng_done; busy falls in the same cycle.
- Engine NACKs entry 3 three times, then acks → entry 3 is issued 4 times with 5000-cycle spacing, the sequence continues, init_err=0.
- Engine always NACKs entry 5 → 4 attempts, then init_err=1, init_done=0, busy=0. No write for entry 6.
- Table entry 2=16'hFE0A, entry 4=16'hFFxx → 10000-cycle wait before entry 3 is fetched, no write issued for entries 2 or 4, init_done=1 after entry 3.
- After init_done, host_req with addr 8'h40, data 8'hD0, engine NACK → eng_reg_*=40/D0, host_ack pulse with host_err=1, no retry.
- start pulse during a host write, and a separate reset asserted while eng_req=1 → host acked first, then init restarts from index 0. On reset, all outputs are 0 asynchronously.

Source files
------------

// File: rtl/sccb_write_scheduler_if.sv
// Bundle of the scheduler's control, table, host and engine signals.
interface sccb_write_scheduler_if #(
    parameter int IDX_W = 5
);
    logic             start;
    logic [IDX_W-1:0] tbl_idx;
    logic [15:0]      tbl_data;
    logic             host_req;
    logic [7:0]       host_addr;
    logic [7:0]       host_data;
    logic             host_ack;
    logic             host_err;
    logic             eng_req;
    logic [7:0]       eng_reg_addr;
    logic [7:0]       eng_reg_data;
    logic             eng_done;
    logic             eng_nack;
    logic             busy;
    logic             init_done;
    logic             init_err;

    modport slave (
        input  start, tbl_data, host_req, host_addr, host_data, eng_done, eng_nack,
        output tbl_idx, host_ack, host_err, eng_req, eng_reg_addr, eng_reg_data,
               busy, init_done, init_err
    );

    modport master (
        output start, tbl_data, host_req, host_addr, host_data, eng_done, eng_nack,
        input  tbl_idx, host_ack, host_err, eng_req, eng_reg_addr, eng_reg_data,
               busy, init_done, init_err
    );
endinterface

// File: rtl/sccb_write_scheduler.sv
// OV7670 init-table walker and host-write arbiter in front of a shared SCCB
// write engine. Inserts post-write delays, retries NACKed table writes.
module sccb_write_scheduler #(
    parameter int NUM_ENTRIES   = 17,
    parameter int IDX_W         = 5,
    parameter int DELAY_SOFTRST = 100000,
    parameter int DELAY_WRITE   = 5000,
    parameter int DELAY_UNIT    = 1000,
    parameter int CNT_W         = 20,
    parameter int MAX_RETRY     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    sccb_write_scheduler_if.slave  bus
);
    localparam int RTR_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] SOFT_LD = CNT_W'(DELAY_SOFTRST - 1);
    localparam logic [CNT_W-1:0] WR_LD   = CNT_W'(DELAY_WRITE - 1);
    localparam logic [CNT_W-1:0] UNIT    = CNT_W'(DELAY_UNIT);
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [RTR_W-1:0] MAXR    = RTR_W'(MAX_RETRY);

    typedef enum logic [2:0] {IDLE, WAIT, FETCH, ISSUE, HOST, DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [RTR_W-1:0] retry_q;
    logic             pend_q;
    logic             eng_req_q;
    logic [7:0]       addr_q, data_q;
    logic             host_ack_q, host_err_q;
    logic             done_q, err_q;

    logic [CNT_W-1:0] mark_ld_d;
    logic [CNT_W-1:0] post_ld_d;
    logic             run_go_d;

    // Delay loads and the (re)start decision. A restart never interrupts an
    // engine write: in ISSUE it waits for eng_done, and HOST returns via IDLE.
    always_comb begin
        mark_ld_d = CNT_W'(bus.tbl_data[7:0]) * UNIT - CNT_W'(1);
        post_ld_d = (addr_q == 8'h12 && data_q[7]) ? SOFT_LD : WR_LD;
        run_go_d  = 1'b0;
        if (bus.start || pend_q) begin
            case (state_q)
                IDLE, WAIT, FETCH: run_go_d = 1'b1;
                ISSUE:             run_go_d = bus.eng_done;
                default:           run_go_d = 1'b0;
            endcase
        end
    end

    // Main sequencer: table walk, delays, retries, host path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            retry_q    <= '0;
            pend_q     <= 1'b0;
            eng_req_q  <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            host_ack_q <= 1'b0;
            host_err_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            host_ack_q <= 1'b0;
            host_err_q <= 1'b0;
            if (run_go_d) begin
                done_q    <= 1'b0;
                err_q     <= 1'b0;
                idx_q     <= '0;
                retry_q   <= '0;
                cnt_q     <= SOFT_LD;
                pend_q    <= 1'b0;
                eng_req_q <= 1'b0;
                state_q   <= WAIT;
            end else begin
                if (bus.start && state_q != IDLE) pend_q <= 1'b1;
                case (state_q)
                    IDLE: if (bus.host_req) begin
                        addr_q    <= bus.host_addr;
                        data_q    <= bus.host_data;
                        eng_req_q <= 1'b1;
                        state_q   <= HOST;
                    end
                    WAIT: begin
                        if (cnt_q == '0) state_q <= FETCH;
                        else             cnt_q   <= cnt_q - CNT_W'(1);
                    end
                    FETCH: begin
                        if (bus.tbl_data[15:8] == 8'hFF) begin
                            state_q <= DONE;
                        end else if (bus.tbl_data[15:8] == 8'hFE) begin
                            // Advancing off the table end through a marker finishes the run.
                            if (idx_q == LAST) begin
                                state_q <= DONE;
                            end else begin
                                idx_q <= idx_q + IDX_W'(1);
                                if (bus.tbl_data[7:0] != 8'h00) begin
                                    cnt_q   <= mark_ld_d;
                                    state_q <= WAIT;
                                end
                            end
                        end else begin
                            addr_q    <= bus.tbl_data[15:8];
                            data_q    <= bus.tbl_data[7:0];
                            eng_req_q <= 1'b1;
                            state_q   <= ISSUE;
                        end
                    end
                    ISSUE: if (bus.eng_done) begin
                        eng_req_q <= 1'b0;
                        if (!bus.eng_nack) begin
                            if (idx_q == LAST) begin
                                state_q <= DONE;
                            end else begin
                                idx_q   <= idx_q + IDX_W'(1);
                                retry_q <= '0;
                                cnt_q   <= post_ld_d;
                                state_q <= WAIT;
                            end
                        end else if (retry_q < MAXR) begin
                            retry_q <= retry_q + RTR_W'(1);
                            cnt_q   <= WR_LD;
                            state_q <= WAIT;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    HOST: if (bus.eng_done) begin
                        eng_req_q  <= 1'b0;
                        host_ack_q <= 1'b1;
                        host_err_q <= bus.eng_nack;
                        state_q    <= IDLE;
                    end
                    DONE: begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.tbl_idx      = idx_q;
    assign bus.eng_req      = eng_req_q;
    assign bus.eng_reg_addr = addr_q;
    assign bus.eng_reg_data = data_q;
    assign bus.host_ack     = host_ack_q;
    assign bus.host_err     = host_err_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.init_done    = done_q;
    assign bus.init_err     = err_q;
endmodule

// File: tb/tb_sccb_write_scheduler.sv
// Scoreboard bench for sccb_write_scheduler with shortened delays.
module tb_sccb_write_scheduler;
    localparam int NE   = 17;
    localparam int SOFT = 200;
    localparam int WR   = 50;
    localparam int UNIT = 10;
    localparam int LAT  = 40;
    localparam int TMO  = 2000;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sccb_write_scheduler_if #(.IDX_W(5)) bus();

    logic [15:0] tbl [32];
    assign bus.tbl_data = tbl[bus.tbl_idx];

    sccb_write_scheduler #(
        .NUM_ENTRIES(NE), .IDX_W(5), .DELAY_SOFTRST(SOFT), .DELAY_WRITE(WR),
        .DELAY_UNIT(UNIT), .CNT_W(20), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         gap;
        logic       nack;
        int         st;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   mark   = 0;

    task automatic set_default();
        for (int i = 0; i < 32; i++) tbl[i] = 16'h0000;
        tbl[0] = 16'h1280;
        for (int i = 1; i < NE; i++) tbl[i] = {8'(8'h20 + i), 8'(i * 3)};
    endtask

    task automatic push(input int idx, input int gap, input logic nack, input int st);
        sb.push_back('{tbl[idx][15:8], tbl[idx][7:0], gap, nack, st});
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        mark = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (bus.eng_req) begin ok = 1'b1; break; end
        end
    endtask

    // Engine model: accept the request, answer after LAT cycles; optionally
    // pulse start st cycles into the write.
    task automatic serve(input logic nack, input int st, output logic [7:0] a,
                         output logic [7:0] d, output int gap, output bit ok);
        wait_req(ok);
        a = bus.eng_reg_addr; d = bus.eng_reg_data; gap = cyc - mark;
        if (!ok) return;
        for (int i = 0; i < LAT - 1; i++) begin
            if (i == st) bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        bus.eng_done = 1'b1; bus.eng_nack = nack; mark = cyc + 1;
        @(negedge clk);
        bus.eng_done = 1'b0; bus.eng_nack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.init_done, bus.init_err, bus.eng_req, bus.host_ack, bus.host_err} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 000000",
                {bus.busy, bus.init_done, bus.init_err, bus.eng_req, bus.host_ack, bus.host_err});
        end
        checks++;
        if ({bus.tbl_idx, bus.eng_reg_addr, bus.eng_reg_data} !== 21'h0) begin
            errors++; $display("FAIL reset_data got %h want 0", {bus.tbl_idx, bus.eng_reg_addr, bus.eng_reg_data});
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.eng_req !== 1'b0) begin
            errors++; $display("FAIL no_autostart got busy=%b req=%b want 0 0", bus.busy, bus.eng_req);
        end
    endtask

    task automatic test_full_init();
        logic [7:0] a, d; int g; bit ok; exp_t e;
        set_default();
        push(0, SOFT + 1, 1'b0, -1);
        push(1, SOFT + 1, 1'b0, -1);
        for (int i = 2; i < NE; i++) push(i, WR + 1, 1'b0, -1);
        pulse_start();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            serve(e.nack, e.st, a, d, g, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL full_write timeout"); sb.delete(); break; end
            if (a !== e.a || d !== e.d || g !== e.gap) begin
                errors++; $display("FAIL full_write got %h/%h gap %0d want %h/%h gap %0d", a, d, g, e.a, e.d, e.gap);
            end
        end
        checks++;
        if (bus.busy !== 1'b1 || bus.init_done !== 1'b0) begin
            errors++; $display("FAIL full_done_state got busy=%b done=%b want 1 0", bus.busy, bus.init_done);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.init_done !== 1'b1 || bus.init_err !== 1'b0) begin
            errors++; $display("FAIL full_end got busy=%b done=%b err=%b want 0 1 0", bus.busy, bus.init_done, bus.init_err);
        end
    endtask

    task automatic test_nack_retry();
        logic [7:0] a, d; int g; bit ok; exp_t e;
        set_default();
        push(0, SOFT + 1, 1'b0, -1);
        push(1, SOFT + 1, 1'b0, -1);
        push(2, WR + 1, 1'b0, -1);
        for (int i = 0; i < 3; i++) push(3, WR + 1, 1'b1, -1);
        push(3, WR + 1, 1'b0, -1);
        for (int i = 4; i < NE; i++) push(i, WR + 1, 1'b0, -1);
        pulse_start();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            serve(e.nack, e.st, a, d, g, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL retry_write timeout"); sb.delete(); break; end
            if (a !== e.a || d !== e.d || g !== e.gap) begin
                errors++; $display("FAIL retry_write got %h/%h gap %0d want %h/%h gap %0d", a, d, g, e.a, e.d, e.gap);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.init_done !== 1'b1 || bus.init_err !== 1'b0) begin
            errors++; $display("FAIL retry_end got busy=%b done=%b err=%b want 0 1 0", bus.busy, bus.init_done, bus.init_err);
        end
    endtask

    task automatic test_nack_abort();
        logic [7:0] a, d; int g; bit ok; exp_t e; bit seen;
        set_default();
        push(0, SOFT + 1, 1'b0, -1);
        push(1, SOFT + 1, 1'b0, -1);
        for (int i = 2; i < 5; i++) push(i, WR + 1, 1'b0, -1);
        for (int i = 0; i < 4; i++) push(5, WR + 1, 1'b1, -1);
        pulse_start();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            serve(e.nack, e.st, a, d, g, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL abort_write timeout"); sb.delete(); break; end
            if (a !== e.a || d !== e.d || g !== e.gap) begin
                errors++; $display("FAIL abort_write got %h/%h gap %0d want %h/%h gap %0d", a, d, g, e.a, e.d, e.gap);
            end
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.init_done !== 1'b0 || bus.init_err !== 1'b1) begin
            errors++; $display("FAIL abort_end got busy=%b done=%b err=%b want 0 0 1", bus.busy, bus.init_done, bus.init_err);
        end
        seen = 1'b0;
        repeat (SOFT + WR) begin @(negedge clk); if (bus.eng_req) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_more got req_seen=%b want 0", seen); end
    endtask

    task automatic test_markers();
        logic [7:0] a, d; int g; bit ok; exp_t e; bit seen; bit fin;
        set_default();
        tbl[2] = 16'hFE0A;
        tbl[4] = 16'hFF00;
        push(0, SOFT + 1, 1'b0, -1);
        push(1, SOFT + 1, 1'b0, -1);
        push(3, WR + 2 + 10 * UNIT, 1'b0, -1);
        pulse_start();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            serve(e.nack, e.st, a, d, g, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL marker_write timeout"); sb.delete(); break; end
            if (a !== e.a || d !== e.d || g !== e.gap) begin
                errors++; $display("FAIL marker_write got %h/%h gap %0d want %h/%h gap %0d", a, d, g, e.a, e.d, e.gap);
            end
        end
        seen = 1'b0; fin = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (bus.eng_req) seen = 1'b1;
            if (!bus.busy) begin fin = 1'b1; break; end
        end
        checks++;
        if (fin !== 1'b1 || seen !== 1'b0) begin
            errors++; $display("FAIL marker_finish got fin=%b req_seen=%b want 1 0", fin, seen);
        end
        checks++;
        if (bus.init_done !== 1'b1 || bus.init_err !== 1'b0 || bus.tbl_idx !== 5'd4) begin
            errors++; $display("FAIL marker_end got done=%b err=%b idx=%0d want 1 0 4", bus.init_done, bus.init_err, bus.tbl_idx);
        end
    endtask

    task automatic test_host();
        logic [7:0] a, d; int g; bit ok; exp_t e; bit seen;
        sb.push_back('{8'h40, 8'hD0, 0, 1'b1, -1});
        @(negedge clk);
        bus.host_req = 1'b1; bus.host_addr = 8'h40; bus.host_data = 8'hD0;
        mark = cyc + 1;
        e = sb.pop_front();
        serve(e.nack, e.st, a, d, g, ok);
        checks++;
        if (!ok || a !== e.a || d !== e.d || g !== e.gap) begin
            errors++; $display("FAIL host_write got ok=%b %h/%h gap %0d want %h/%h gap %0d", ok, a, d, g, e.a, e.d, e.gap);
        end
        checks++;
        if (bus.host_ack !== 1'b1 || bus.host_err !== 1'b1 || bus.init_done !== 1'b1) begin
            errors++; $display("FAIL host_ack got ack=%b err=%b done=%b want 1 1 1", bus.host_ack, bus.host_err, bus.init_done);
        end
        bus.host_req = 1'b0;
        seen = 1'b0;
        repeat (SOFT + WR) begin @(negedge clk); if (bus.eng_req || bus.host_ack) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL host_no_retry got activity=%b want 0", seen); end
    endtask

    task automatic test_start_during_host();
        logic [7:0] a, d; int g; bit ok; exp_t e;
        set_default();
        @(negedge clk);
        bus.host_req = 1'b1; bus.host_addr = 8'h55; bus.host_data = 8'hAA;
        mark = cyc + 1;
        serve(1'b0, 5, a, d, g, ok);
        checks++;
        if (!ok || a !== 8'h55 || d !== 8'hAA || bus.host_ack !== 1'b1 || bus.host_err !== 1'b0) begin
            errors++; $display("FAIL pend_host got ok=%b %h/%h ack=%b err=%b want 55/AA 1 0", ok, a, d, bus.host_ack, bus.host_err);
        end
        bus.host_req = 1'b0;
        push(0, SOFT + 2, 1'b0, -1);
        push(1, SOFT + 1, 1'b0, 3);
        push(0, SOFT + 1, 1'b0, -1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            serve(e.nack, e.st, a, d, g, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL pend_write timeout"); sb.delete(); break; end
            if (a !== e.a || d !== e.d || g !== e.gap) begin
                errors++; $display("FAIL pend_write got %h/%h gap %0d want %h/%h gap %0d", a, d, g, e.a, e.d, e.gap);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        bit ok; bit seen;
        wait_req(ok);
        checks++;
        if (!ok || bus.eng_reg_addr !== tbl[1][15:8]) begin
            errors++; $display("FAIL rst_pre got ok=%b addr=%h want %h", ok, bus.eng_reg_addr, tbl[1][15:8]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.init_done, bus.init_err, bus.eng_req, bus.host_ack, bus.host_err} !== 6'b0 ||
            {bus.tbl_idx, bus.eng_reg_addr, bus.eng_reg_data} !== 21'h0) begin
            errors++; $display("FAIL rst_async got ctrl=%b data=%h want 0 0",
                {bus.busy, bus.init_done, bus.init_err, bus.eng_req, bus.host_ack, bus.host_err},
                {bus.tbl_idx, bus.eng_reg_addr, bus.eng_reg_data});
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (SOFT + WR) begin @(negedge clk); if (bus.eng_req || bus.busy) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rst_idle got activity=%b want 0", seen); end
    endtask

    initial begin
        bus.start = 1'b0; bus.host_req = 1'b0; bus.host_addr = 8'h00; bus.host_data = 8'h00;
        bus.eng_done = 1'b0; bus.eng_nack = 1'b0;
        rst = 1'b1;
        set_default();
        test_reset();
        test_full_init();
        test_nack_retry();
        test_nack_abort();
        test_markers();
        test_host();
        test_start_during_host();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
